// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// exposing the per-bit borrow chain alongside the registered difference.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic             br, br_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [WIDTH-1:0] diff_nxt, bout_nxt;
    logic             busy_nxt, done_nxt;
    logic             a_bit, b_bit, d_bit, nb_bit;

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            br    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            diff  <= '0;
            bout  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            br    <= br_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            diff  <= diff_nxt;
            bout  <= bout_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        br_nxt    = br;
        a_nxt     = a_q;
        b_nxt     = b_q;
        diff_nxt  = diff;
        bout_nxt  = bout;

        a_bit  = a_q[idx];
        b_bit  = b_q[idx];
        d_bit  = a_bit ^ b_bit ^ br;
        nb_bit = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    br_nxt    = bin;
                    idx_nxt   = '0;
                    diff_nxt  = '0;
                    bout_nxt  = '0;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                diff_nxt[idx] = d_bit;
                bout_nxt[idx] = nb_bit;
                br_nxt        = nb_bit;
                // Index is reloaded on every accept, so wrapping past the MSB is harmless.
                idx_nxt       = idx + IW'(1);
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Status flags mirror the state they will be in after this edge.
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic [3:0] bout;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_mis;
    int done_cnt;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .diff (diff),
        .bout (bout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    // Present a request at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        @(negedge clk);
        start = 1'b0;
    endtask

    // From the first RUN cycle, check busy for 4 cycles then the done cycle.
    task automatic run_and_check(input string nm, input logic [3:0] ed, input logic [3:0] eb);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_mis++;
                $display("FAIL %s_busy[%0d]: got busy=%b done=%b exp busy=1 done=0", nm, k, busy, done);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_done: got busy=%b done=%b exp busy=0 done=1", nm, busy, done);
        end
        n_cmp++;
        if (diff !== ed || bout !== eb) begin
            n_mis++;
            $display("FAIL %s_result: got diff=%h bout=%b exp diff=%h bout=%b", nm, diff, bout, ed, eb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (diff !== 4'h0 || bout !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_state: got diff=%h bout=%b busy=%b done=%b exp all 0", diff, bout, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue(4'h9, 4'h3, 1'b0);
        // Operand changes after acceptance must not leak into the result.
        a = 4'hF;
        b = 4'h0;
        bin = 1'b1;
        run_and_check("basic", 4'h6, 4'b0110);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 4'h6 || bout !== 4'b0110) begin
            n_mis++;
            $display("FAIL basic_hold: got done=%b busy=%b diff=%h bout=%b exp 0 0 6 0110", done, busy, diff, bout);
        end
    endtask

    task automatic test_negative();
        issue(4'h3, 4'h9, 1'b0);
        run_and_check("negative", 4'hA, 4'b1000);
        @(negedge clk);
    endtask

    task automatic test_borrow_in();
        issue(4'h0, 4'h0, 1'b1);
        run_and_check("borrow_in", 4'hF, 4'b1111);
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int c0;
        c0 = done_cnt;
        issue(4'h9, 4'h3, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = 4'hF;
        b = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || diff !== 4'h6 || bout !== 4'b0110) begin
            n_mis++;
            $display("FAIL busy_start_result: got done=%b diff=%h bout=%b exp 1 6 0110", done, diff, bout);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt - c0 !== 1 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL busy_start_pulses: got %0d done pulses busy=%b exp 1 pulse busy=0", done_cnt - c0, busy);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'h9, 4'h3, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || diff !== 4'h6 || bout !== 4'b0110) begin
            n_mis++;
            $display("FAIL b2b_first: got done=%b diff=%h bout=%b exp 1 6 0110", done, diff, bout);
        end
        issue(4'h7, 4'h2, 1'b0);
        n_cmp++;
        if (done !== 1'b0 || diff !== 4'h0 || bout !== 4'h0) begin
            n_mis++;
            $display("FAIL b2b_accept: got done=%b diff=%h bout=%b exp 0 0 0000", done, diff, bout);
        end
        run_and_check("b2b_second", 4'h5, 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int c0;
        c0 = done_cnt;
        issue(4'h9, 4'h3, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || diff !== 4'h2 || bout !== 4'b0010) begin
            n_mis++;
            $display("FAIL midrun_partial: got busy=%b diff=%h bout=%b exp 1 2 0010", busy, diff, bout);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (diff !== 4'h0 || bout !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL midrun_async: got diff=%h bout=%b busy=%b done=%b exp all 0", diff, bout, busy, done);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_cnt !== c0) begin
            n_mis++;
            $display("FAIL midrun_no_done: got %0d done pulses exp 0", done_cnt - c0);
        end
        // Start presented together with release: first edge must accept it.
        rst_n = 1'b1;
        issue(4'h5, 4'h5, 1'b0);
        run_and_check("after_reset", 4'h0, 4'b0000);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;
        bin = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_negative();
        test_borrow_in();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on each rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port bin, input, 1 bit: the borrow-in, captured when start is accepted.
REQ-008 The block SHALL have port diff, output, WIDTH bits: the registered difference a - b - bin, modulo 2^WIDTH.
REQ-009 The block SHALL have port bout, output, WIDTH bits: the registered borrow per bit position; bout[WIDTH-1] is the final borrow-out.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking diff and bout valid.

Function
REQ-012 The block SHALL implement a state machine with three states, IDLE, RUN and DONE, with all outputs registered.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL be accepted at that edge:
- a, b and bin are latched internally;
- diff and bout are cleared to 0;
- the bit index is set to 0 and the internal borrow register is loaded with bin;
- the state moves to RUN.
REQ-014 In RUN, each rising edge SHALL process bit i and then increment i, as follows:
- d = a[i] ^ b[i] ^ br
- nb = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br)
- diff[i] <= d, bout[i] <= nb, br <= nb
REQ-015 The edge that processes bit WIDTH-1 SHALL move the state to DONE.
REQ-016 busy SHALL be 1 exactly while the state is RUN, i.e. for WIDTH cycles after the accept edge.
REQ-017 done SHALL be 1 exactly while the state is DONE, i.e. in the single cycle after the last bit edge.
REQ-018 Latency SHALL be exactly WIDTH rising edges from the accept edge to the edge that asserts done.
REQ-019 In DONE with start=0, the next edge SHALL move the state to IDLE.
REQ-020 In DONE with start=1, the request SHALL be accepted back-to-back: done lasts one cycle only, then busy rises.
REQ-021 start SHALL be ignored in RUN: latched operands, the bit index and the outputs are unaffected by it.
REQ-022 Changes on a, b or bin outside the accept edge SHALL have no effect on the result.
REQ-023 diff and bout SHALL hold their final values through DONE and IDLE until the next accepted start clears them.
REQ-024 When bout[WIDTH-1]=1, the result SHALL represent a negative unsigned difference (a < b + bin); no saturation SHALL be applied.

Reset
REQ-025 While rst_n=0, the block SHALL immediately (asynchronously) force:
- state IDLE, bit index 0, borrow register 0;
- diff=0, bout=0, busy=0, done=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-027 The first edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-028 The bench SHALL cover these directed scenarios with WIDTH=4:
- Basic subtraction: a=9, b=3, bin=0, start pulsed -> busy high for 4 cycles, then done one cycle with diff=4'h6, bout=4'b0110.
- Negative result: a=3, b=9, bin=0 -> diff=4'hA, bout=4'b1000 (final borrow=1).
- Borrow-in only: a=0, b=0, bin=1 -> diff=4'hF, bout=4'b1111.
- Start while busy: second start with a=F, b=F issued in the 2nd RUN cycle -> ignored; the first result is unchanged; exactly one done pulse.
- Back-to-back: start held high during the done cycle with a=7, b=2 -> done lasts 1 cycle, the first result is correct, then after 4 more cycles diff=4'h5, bout=4'b0000.
- Reset mid-run: rst_n=0 in the 3rd RUN cycle -> diff=0, bout=0, busy=0, done=0 immediately, with no done pulse; after release a=5, b=5 -> diff=0, bout=0.
